mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Initiator side of the data-memory interface; sits between the multi-cycle datapath's MEM stage control and the word-wide synchronous data memory.
- Accepts one load/store request at a time and drives Mem_WrEn, ALU_MEM_Addr and MEM_DataIn. Consumes MEM_DataOut.
- Converts byte and halfword accesses into word accesses. Sub-word stores use a read-modify-write sequence; loads are extracted and extended.
- Reports completion and misalignment to the control FSM.

Parameters:
BIG_ENDIAN, 0, byte-lane order within a word. 0 means byte at offset 0 is in bits [7:0]; 1 means byte at offset 0 is in bits [31:24].

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request strobe, sampled only in IDLE
is_store  in  1  1 = store, 0 = load
size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved (treated as misaligned)
sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend
addr  in  32  byte address
wdata  in  32  store data; the sub-word is taken from the low bits
rdata  out  32  load result, registered, held until the next load completes
busy  out  1  high while state != IDLE
done  out  1  one-cycle completion pulse
err  out  1  valid with done; 1 = misaligned or reserved size, no memory access made
Mem_WrEn  out  1  memory write enable
ALU_MEM_Addr  out  32  word address {addr[31:2],2'b00}
MEM_DataIn  out  32  memory write data
MEM_DataOut  in  32  memory read data; valid the cycle after a we=0 edge on the same address

Behaviour:
- Reset (async, rst_n=0): state = IDLE. All outputs are 0: rdata, busy, done, err, Mem_WrEn, ALU_MEM_Addr, MEM_DataIn. Mem_WrEn drops immediately, without waiting for clk.
- A reset during WR aborts the write. No partial-state recovery.
- Memory model relied on:
  - Memory samples addr/we/din at each rising edge.
  - Read data appears after that edge.
  - Memory reads on every edge where we=0.
- States: IDLE, RD, CAP, WR, DONE.
- IDLE: start=1 at an edge latches addr, is_store, size, sign_ext and wdata. Next state:
  - misaligned (half with addr[0]=1, word with addr[1:0]!=0, or size=11): DONE with err=1;
  - word store: WR;
  - otherwise: RD.
- RD: ALU_MEM_Addr = latched word address, Mem_WrEn=0. Next state CAP.
- CAP: MEM_DataOut is valid.
  - Load: register the extracted lane into rdata (sign- or zero-extended to 32 bits; word loads unextended). Next state DONE.
  - Sub-word store: register a merged word into MEM_DataIn, replacing only the addressed byte/half lane with wdata[7:0]/wdata[15:0]. Next state WR.
- WR: Mem_WrEn=1 for exactly one cycle. MEM_DataIn is wdata for word stores, the merged word otherwise. Next state DONE.
- DONE: done=1 for one cycle; err as latched. Next state IDLE unconditionally. busy=1 in DONE.
- Outside WR, Mem_WrEn=0.
- ALU_MEM_Addr holds its last value in IDLE.
- Latency, counting the start-sampling edge as edge 0; done is high during cycle:
  - misaligned: 1;
  - word store: 2;
  - load: 3;
  - sub-word store: 4.
- start is ignored while busy. Back-to-back requests: start may be asserted during DONE, but it is only sampled in IDLE.
- The request is fully latched, so input changes after edge 0 have no effect.
- Lane offsets: byte lane = addr[1:0]; half lane = addr[1]. BIG_ENDIAN mirrors the lane index (3-addr[1:0] for bytes, 1-addr[1] for halves).
- err=0 on every non-misaligned completion. rdata is unchanged on stores and on errors.

Test Plan:
- Reset mid-WR: assert rst_n=0 while Mem_WrEn=1 -> Mem_WrEn=0 immediately; the memory word is unchanged; all outputs are 0; state is IDLE.
- Word store then load: store 0xDEADBEEF at 0x40; done in cycle 2 -> load word 0x40, done in cycle 3, rdata=0xDEADBEEF, err=0.
- Byte store RMW (BIG_ENDIAN=0): word 0x40 = 0x11223344; sb 0xAA at 0x42 -> exactly one Mem_WrEn pulse with MEM_DataIn=0x11AA3344; done in cycle 4.
- Signed/unsigned loads on 0x11AA3344: lb 0x42 -> 0xFFFFFFAA; lbu 0x42 -> 0x000000AA; lh 0x42 -> 0x000011AA; lhu 0x40 -> 0x00003344.
- Misalignment: lh at 0x41, lw at 0x42, size=11 -> done in cycle 1 with err=1; Mem_WrEn never asserted; rdata unchanged.
- Busy rejection: pulse start again during RD with a different addr -> ignored; the first request completes; the next start in IDLE is accepted.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: initiator side of the word-wide synchronous data-memory interface.
// Takes one load/store request at a time from the MEM-stage control. Byte and halfword
// stores become read-modify-write sequences; loads are lane-extracted and extended.
//
// Ports:
//   clk, rst_n      clock (rising edge) and asynchronous active-low reset
//   start           request strobe, sampled only in IDLE
//   is_store        1 = store, 0 = load
//   size            00 byte, 01 half, 10 word, 11 reserved (reported as misaligned)
//   sign_ext        loads only: 1 = sign-extend, 0 = zero-extend
//   addr, wdata     byte address and store data (sub-word taken from the low bits)
//   rdata           registered load result, held until the next load completes
//   busy, done, err status to the control FSM; err is valid with the done pulse
//   Mem_WrEn, ALU_MEM_Addr, MEM_DataIn, MEM_DataOut   memory interface
module mem_access_ctrl #(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_store,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        Mem_WrEn,
    output logic [31:0] ALU_MEM_Addr,
    output logic [31:0] MEM_DataIn,
    input  logic [31:0] MEM_DataOut
);

    typedef enum logic [2:0] {StIdle, StRd, StCap, StWr, StDone} state_e;

    state_e      state_q;
    logic [1:0]  lane_q;   // byte offset within the word; upper bits live in ALU_MEM_Addr
    logic        store_q;
    logic [1:0]  size_q;
    logic        sext_q;
    logic [31:0] wdata_q;

    logic        misalign;
    logic [1:0]  blane;
    logic        hlane;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic [31:0] load_val;
    logic [31:0] merged;

    // Evaluated on the live inputs, since it decides the exit from IDLE.
    assign misalign = (size == 2'b11) ||
                      (size == 2'b01 && addr[0]) ||
                      (size == 2'b10 && addr[1:0] != 2'b00);

    always_comb begin
        // Big-endian mirrors the lane index.
        blane  = lane_q ^ {2{BIG_ENDIAN}};
        hlane  = lane_q[1] ^ BIG_ENDIAN;
        rbyte  = MEM_DataOut[7:0];
        merged = MEM_DataOut;
        unique case (blane)
            2'd0: begin rbyte = MEM_DataOut[7:0];   merged[7:0]   = wdata_q[7:0]; end
            2'd1: begin rbyte = MEM_DataOut[15:8];  merged[15:8]  = wdata_q[7:0]; end
            2'd2: begin rbyte = MEM_DataOut[23:16]; merged[23:16] = wdata_q[7:0]; end
            2'd3: begin rbyte = MEM_DataOut[31:24]; merged[31:24] = wdata_q[7:0]; end
        endcase
        rhalf = hlane ? MEM_DataOut[31:16] : MEM_DataOut[15:0];
        if (size_q == 2'b01) begin
            merged = MEM_DataOut;
            if (hlane) merged[31:16] = wdata_q[15:0];
            else       merged[15:0]  = wdata_q[15:0];
        end
        case (size_q)
            2'b00:   load_val = {{24{sext_q & rbyte[7]}}, rbyte};
            2'b01:   load_val = {{16{sext_q & rhalf[15]}}, rhalf};
            default: load_val = MEM_DataOut;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            lane_q       <= 2'b00;
            store_q      <= 1'b0;
            size_q       <= 2'b00;
            sext_q       <= 1'b0;
            wdata_q      <= '0;
            rdata        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            Mem_WrEn     <= 1'b0;
            ALU_MEM_Addr <= '0;
            MEM_DataIn   <= '0;
        end else begin
            done     <= 1'b0;
            err      <= 1'b0;
            Mem_WrEn <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        lane_q  <= addr[1:0];
                        store_q <= is_store;
                        size_q  <= size;
                        sext_q  <= sign_ext;
                        wdata_q <= wdata;
                        busy    <= 1'b1;
                        if (misalign) begin
                            // No memory access: address bus keeps its last value.
                            state_q <= StDone;
                            done    <= 1'b1;
                            err     <= 1'b1;
                        end else begin
                            ALU_MEM_Addr <= {addr[31:2], 2'b00};
                            if (is_store && size == 2'b10) begin
                                state_q    <= StWr;
                                Mem_WrEn   <= 1'b1;
                                MEM_DataIn <= wdata;
                            end else begin
                                state_q <= StRd;
                            end
                        end
                    end
                end
                StRd: state_q <= StCap;
                StCap: begin
                    if (store_q) begin
                        state_q    <= StWr;
                        Mem_WrEn   <= 1'b1;
                        MEM_DataIn <= merged;
                    end else begin
                        state_q <= StDone;
                        rdata   <= load_val;
                        done    <= 1'b1;
                    end
                end
                StWr: begin
                    state_q <= StDone;
                    done    <= 1'b1;
                end
                StDone: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl with a behavioural synchronous word memory. The driver pushes
// expected completions and expected memory writes into queues; monitors pop and compare.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, is_store, sign_ext;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        busy, done, err;
    logic        Mem_WrEn;
    logic [31:0] ALU_MEM_Addr, MEM_DataIn, MEM_DataOut;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_seen = 0;

    typedef struct {
        logic [31:0] rd;
        logic        er;
        int          e0;
        int          lat;
    } exp_t;
    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;
    exp_t dq[$];
    wr_t  wq[$];

    logic [31:0] mem [0:63];

    mem_access_ctrl #(.BIG_ENDIAN(1'b0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .is_store     (is_store),
        .size         (size),
        .sign_ext     (sign_ext),
        .addr         (addr),
        .wdata        (wdata),
        .rdata        (rdata),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .Mem_WrEn     (Mem_WrEn),
        .ALU_MEM_Addr (ALU_MEM_Addr),
        .MEM_DataIn   (MEM_DataIn),
        .MEM_DataOut  (MEM_DataOut)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous memory: write when we=1, otherwise read into MEM_DataOut.
    always @(posedge clk) begin
        if (Mem_WrEn) mem[ALU_MEM_Addr[7:2]] <= MEM_DataIn;
        else          MEM_DataOut <= mem[ALU_MEM_Addr[7:2]];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Completion monitor.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (dq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no completion");
            end else begin
                exp_t e;
                e = dq.pop_front();
                chk("rdata", rdata, e.rd);
                chk("err", {31'd0, err}, {31'd0, e.er});
                chk("latency", cyc - e.e0 + 1, e.lat);
                chk("busy_at_done", {31'd0, busy}, 32'd1);
            end
            done_seen++;
        end
    end

    // Memory-write monitor.
    always @(negedge clk) begin
        if (Mem_WrEn) begin
            if (wq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got write %h to %h expected none",
                         MEM_DataIn, ALU_MEM_Addr);
            end else begin
                wr_t w;
                w = wq.pop_front();
                chk("wr_addr", ALU_MEM_Addr, w.a);
                chk("wr_data", MEM_DataIn, w.d);
            end
        end
    end

    task automatic wait_done(input int n);
        for (int i = 0; i < 12 && done_seen == n; i++) @(posedge clk);
        if (done_seen == n) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within 12 cycles");
        end
    endtask

    task automatic scramble();
        start    = 1'b0;
        addr     = $urandom;
        wdata    = $urandom;
        size     = 2'($urandom);
        is_store = 1'($urandom);
        sign_ext = 1'($urandom);
    endtask

    task automatic req(input logic st, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err, input int lat,
                       input logic wr, input logic [31:0] wexp);
        int n;
        n = done_seen;
        @(negedge clk);
        start = 1'b1; is_store = st; size = sz; sign_ext = sx; addr = a; wdata = wd;
        if (wr) wq.push_back('{a: {a[31:2], 2'b00}, d: wexp});
        @(posedge clk);
        #1;
        dq.push_back('{rd: exp_rd, er: exp_err, e0: cyc, lat: lat});
        scramble();
        wait_done(n);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        start = 1'b0; is_store = 1'b0; size = 2'b00; sign_ext = 1'b0;
        addr = '0; wdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_wren", {31'd0, Mem_WrEn}, 32'd0);
        chk("rst_addr", ALU_MEM_Addr, 32'd0);
        chk("rst_din", MEM_DataIn, 32'd0);
        rst_n = 1'b1;

        // Word store / load.
        req(1, 2'b10, 0, 32'h40, 32'hDEADBEEF, 32'h0, 0, 2, 1, 32'hDEADBEEF);
        req(0, 2'b10, 0, 32'h40, 32'h0, 32'hDEADBEEF, 0, 3, 0, 32'h0);
        req(1, 2'b10, 0, 32'h40, 32'h11223344, 32'hDEADBEEF, 0, 2, 1, 32'h11223344);
        // Byte RMW and sub-word loads.
        req(1, 2'b00, 0, 32'h42, 32'h123456AA, 32'hDEADBEEF, 0, 4, 1, 32'h11AA3344);
        req(0, 2'b00, 1, 32'h42, 32'h0, 32'hFFFFFFAA, 0, 3, 0, 32'h0);
        req(0, 2'b00, 0, 32'h42, 32'h0, 32'h000000AA, 0, 3, 0, 32'h0);
        req(0, 2'b01, 1, 32'h42, 32'h0, 32'h000011AA, 0, 3, 0, 32'h0);
        req(0, 2'b01, 0, 32'h40, 32'h0, 32'h00003344, 0, 3, 0, 32'h0);
        // Half RMW in the low lane, then signed loads in each byte lane.
        req(1, 2'b01, 0, 32'h40, 32'hFFFF8001, 32'h00003344, 0, 4, 1, 32'h11AA8001);
        req(0, 2'b01, 1, 32'h40, 32'h0, 32'hFFFF8001, 0, 3, 0, 32'h0);
        req(0, 2'b00, 1, 32'h43, 32'h0, 32'h00000011, 0, 3, 0, 32'h0);
        req(0, 2'b00, 1, 32'h40, 32'h0, 32'h00000001, 0, 3, 0, 32'h0);
        req(0, 2'b00, 1, 32'h41, 32'h0, 32'hFFFFFF80, 0, 3, 0, 32'h0);
        // Misaligned / reserved: no write, rdata held.
        req(0, 2'b01, 1, 32'h41, 32'h0, 32'hFFFFFF80, 1, 1, 0, 32'h0);
        req(0, 2'b10, 0, 32'h42, 32'h0, 32'hFFFFFF80, 1, 1, 0, 32'h0);
        req(0, 2'b11, 0, 32'h40, 32'h0, 32'hFFFFFF80, 1, 1, 0, 32'h0);
        req(1, 2'b01, 0, 32'h43, 32'h55555555, 32'hFFFFFF80, 1, 1, 0, 32'h0);
        req(1, 2'b10, 0, 32'h41, 32'h66666666, 32'hFFFFFF80, 1, 1, 0, 32'h0);

        // Busy rejection: a store pulsed during RD must be ignored.
        n = done_seen;
        @(negedge clk);
        start = 1'b1; is_store = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = 32'h40;
        @(posedge clk);
        #1;
        dq.push_back('{rd: 32'h11AA8001, er: 1'b0, e0: cyc, lat: 3});
        scramble();
        @(negedge clk);
        chk("busy_in_rd", {31'd0, busy}, 32'd1);
        start = 1'b1; is_store = 1'b1; size = 2'b10; addr = 32'h44; wdata = 32'h77777777;
        @(posedge clk);
        #1;
        scramble();
        wait_done(n);
        @(negedge clk);
        chk("idle_after_done", {31'd0, busy}, 32'd0);
        req(0, 2'b00, 0, 32'h43, 32'h0, 32'h00000011, 0, 3, 0, 32'h0);

        // Reset in the middle of a write aborts it.
        req(1, 2'b10, 0, 32'h48, 32'h5A5A1234, 32'h00000011, 0, 2, 1, 32'h5A5A1234);
        @(negedge clk);
        start = 1'b1; is_store = 1'b1; size = 2'b10; addr = 32'h48; wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        scramble();
        chk("wren_before_abort", {31'd0, Mem_WrEn}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_wren", {31'd0, Mem_WrEn}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_err", {31'd0, err}, 32'd0);
        chk("abort_rdata", rdata, 32'd0);
        chk("abort_addr", ALU_MEM_Addr, 32'd0);
        chk("abort_din", MEM_DataIn, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        req(0, 2'b10, 0, 32'h48, 32'h0, 32'h5A5A1234, 0, 3, 0, 32'h0);

        repeat (3) @(negedge clk);
        chk("pending_done", dq.size(), 32'd0);
        chk("pending_writes", wq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test expected finish before 100000");
        $fatal(1);
    end

endmodule
